tiny_rv_wb: RTL and testbench

Write-back stage of the tiny_rv core: captures the memory-stage result and commits it to the register file write port. Handles load-data alignment and sign/zero extension, and stalls the pipe while a load response is outstanding. Drives the two operand-forwarding sources (`of1_*` from the memory stage, `of2_*` from write-back) consumed by the register-read stage.

---
 rtl/tiny_rv_pkg.sv | 36 +++
 rtl/tiny_rv_load_align.sv | 41 ++++
 rtl/tiny_rv_wb.sv | 135 +++++++++++++
 tb/tb_tiny_rv_wb.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_rv_pkg.sv
// Shared constants for the tiny_rv core: opcodes, load funct3 codes and the
// write-back FSM state type.
package tiny_rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

  // True for every opcode that produces a register-file write.
  function automatic logic opcode_writes(input logic [6:0] opcode);
    logic writes;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_OP_IMM, OPC_OP, OPC_LOAD: writes = 1'b1;
      default:                      writes = 1'b0;
    endcase
    return writes;
  endfunction

endpackage

// File: rtl/tiny_rv_load_align.sv
// Load-data aligner: selects the addressed byte/half of a little-endian word
// and sign- or zero-extends it according to funct3.
module tiny_rv_load_align
  import tiny_rv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] aligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    unique case (addr_lo)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
  end

  // Misaligned halfword: addr_lo[0] is dropped.
  assign half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    aligned = rdata;
    case (funct3)
      F3_LB:   aligned = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  aligned = {24'h0, byte_v};
      F3_LH:   aligned = {{16{half_v[15]}}, half_v};
      F3_LHU:  aligned = {16'h0, half_v};
      F3_LW:   aligned = rdata;
      default: aligned = rdata;
    endcase
  end

endmodule

// File: rtl/tiny_rv_wb.sv
// tiny_rv write-back stage: register-file commit, load wait/alignment and
// forwarding sources. Define TINY_RV_WB_RETIRE_CNT_EN to add the o_instret counter.
module tiny_rv_wb
  import tiny_rv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_pipe_stall,
  input  logic        mem_valid,
  input  logic [6:0]  mem_opcode,
  input  logic [4:0]  mem_rd,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_result,
  input  logic [1:0]  mem_addr_lo,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wr_en,
  output logic [4:0]  wr_reg,
  output logic [31:0] wr_data,
  output logic [4:0]  of1_reg,
  output logic [31:0] of1_val,
  output logic [4:0]  of2_reg,
  output logic [31:0] of2_val,
  output logic [4:0]  o_mem_load_rd,
`ifdef TINY_RV_WB_RETIRE_CNT_EN
  output logic        o_stall_req,
  output logic [63:0] o_instret
`else
  output logic        o_stall_req
`endif
);

  logic mem_writes;
  logic mem_is_load;
  logic capture;
  logic load_rsp;

  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [2:0]  wb_funct3_q;
  logic [1:0]  wb_addr_lo_q;
  logic [31:0] wb_result_q;
  logic        wb_is_load_q;

  wb_state_t   state_q, state_d;
  logic [31:0] load_data;

  assign mem_writes  = opcode_writes(mem_opcode);
  assign mem_is_load = (mem_opcode == OPC_LOAD);
  assign capture     = !i_pipe_stall;
  assign load_rsp    = (state_q == WAIT_LOAD) && dmem_rvalid;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_funct3_q  <= 3'd0;
      wb_addr_lo_q <= 2'd0;
      wb_result_q  <= 32'd0;
      wb_is_load_q <= 1'b0;
    end else if (capture) begin
      wb_valid_q   <= mem_valid;
      wb_rd_q      <= mem_writes ? mem_rd : 5'd0;
      wb_funct3_q  <= mem_funct3;
      wb_addr_lo_q <= mem_addr_lo;
      wb_result_q  <= mem_result;
      wb_is_load_q <= mem_is_load;
    end
  end

  // A load captured on the same edge as the old response keeps us waiting.
  always_comb begin
    state_d = state_q;
    if (load_rsp) begin
      state_d = IDLE;
    end
    if (capture && mem_valid && mem_is_load) begin
      state_d = WAIT_LOAD;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  tiny_rv_load_align u_load_align (
    .rdata   (dmem_rdata),
    .funct3  (wb_funct3_q),
    .addr_lo (wb_addr_lo_q),
    .aligned (load_data)
  );

  always_comb begin
    wr_reg = wb_rd_q;
    if (wb_is_load_q) begin
      wr_en   = load_rsp && (wb_rd_q != 5'd0);
      wr_data = load_data;
    end else begin
      wr_en   = wb_valid_q && (wb_rd_q != 5'd0);
      wr_data = wb_result_q;
    end
  end

  assign o_stall_req = (state_q == WAIT_LOAD) && !dmem_rvalid;

  assign of2_reg = wr_en ? wr_reg : 5'd0;
  assign of2_val = wr_data;

  assign of1_reg       = (mem_valid && mem_writes && !mem_is_load) ? mem_rd : 5'd0;
  assign of1_val       = mem_result;
  assign o_mem_load_rd = (mem_valid && mem_is_load) ? mem_rd : 5'd0;

`ifdef TINY_RV_WB_RETIRE_CNT_EN
  logic [63:0] instret_q;
  logic [1:0]  retire_inc;

  // A load response and a captured non-load can retire on the same edge.
  assign retire_inc = {1'b0, capture && mem_valid && !mem_is_load} + {1'b0, load_rsp};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      instret_q <= 64'd0;
    end else begin
      instret_q <= instret_q + 64'(retire_inc);
    end
  end

  assign o_instret = instret_q;
`endif

endmodule

// File: tb/tb_tiny_rv_wb.sv
// Self-checking bench for tiny_rv_wb: directed scenarios followed by random
// instruction streams checked against an instruction-level reference model.
module tb_tiny_rv_wb;

  localparam logic [6:0] LOAD_OP = 7'b0000011;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_pipe_stall;
  logic        mem_valid;
  logic [6:0]  mem_opcode;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_result;
  logic [1:0]  mem_addr_lo;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [4:0]  of1_reg;
  logic [31:0] of1_val;
  logic [4:0]  of2_reg;
  logic [31:0] of2_val;
  logic [4:0]  o_mem_load_rd;
  logic        o_stall_req;
`ifdef TINY_RV_WB_RETIRE_CNT_EN
  logic [63:0] o_instret;
`endif

  // The hazard unit here only reflects this stage's own stall request.
  assign i_pipe_stall = o_stall_req;

  tiny_rv_wb dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_pipe_stall  (i_pipe_stall),
    .mem_valid     (mem_valid),
    .mem_opcode    (mem_opcode),
    .mem_rd        (mem_rd),
    .mem_funct3    (mem_funct3),
    .mem_result    (mem_result),
    .mem_addr_lo   (mem_addr_lo),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .wr_en         (wr_en),
    .wr_reg        (wr_reg),
    .wr_data       (wr_data),
    .of1_reg       (of1_reg),
    .of1_val       (of1_val),
    .of2_reg       (of2_reg),
    .of2_val       (of2_val),
    .o_mem_load_rd (o_mem_load_rd),
`ifdef TINY_RV_WB_RETIRE_CNT_EN
    .o_stall_req   (o_stall_req),
    .o_instret     (o_instret)
`else
    .o_stall_req   (o_stall_req)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        v;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] res;
    logic [1:0]  lo;
    int unsigned lat;
    logic [31:0] word;
  } instr_t;

  int          checks = 0;
  int          failures = 0;
  instr_t      cur, pres, nxt;
  logic        ld_pending;
  int unsigned ld_wait;
  logic [63:0] instret_m;
  logic        stray;
  logic        exp_rv;
  logic        exp_stall;
  int          stall_cnt;

  function automatic instr_t mk(input logic v, input logic [6:0] op, input logic [4:0] rd,
                                input logic [2:0] f3, input logic [31:0] res,
                                input logic [1:0] lo, input int unsigned lat,
                                input logic [31:0] word);
    instr_t t;
    t.v = v; t.op = op; t.rd = rd; t.f3 = f3; t.res = res; t.lo = lo; t.lat = lat;
    t.word = word;
    return t;
  endfunction

  function automatic logic writes(input logic [6:0] op);
    return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                      7'b0010011, 7'b0110011, 7'b0000011};
  endfunction

  function automatic logic [31:0] ref_align(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] lo);
    logic [31:0] b, h;
    b = (w >> (8 * int'(lo))) & 32'hFF;
    h = (w >> (16 * int'(lo[1]))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    cur        = mk(1'b0, 7'd0, 5'd0, 3'd0, 32'd0, 2'd0, 0, 32'd0);
    ld_pending = 1'b0;
    ld_wait    = 0;
    instret_m  = 64'd0;
  endtask

  task automatic drive_pres();
    mem_valid   = pres.v;
    mem_opcode  = pres.op;
    mem_rd      = pres.rd;
    mem_funct3  = pres.f3;
    mem_result  = pres.res;
    mem_addr_lo = pres.lo;
  endtask

  // Presents inputs for one cycle and checks every output against the model.
  task automatic drive_and_check();
    logic       exp_wr_en;
    logic [4:0] cur_rd;
    logic [4:0] exp_of1;
    @(negedge i_clk);
    exp_rv      = ld_pending && (ld_wait == 0);
    exp_stall   = ld_pending && !exp_rv;
    dmem_rvalid = ld_pending ? exp_rv : stray;
    dmem_rdata  = exp_rv ? cur.word : $urandom();
    if (!exp_stall) pres = nxt;
    drive_pres();
    #1;
    cur_rd    = writes(cur.op) ? cur.rd : 5'd0;
    exp_wr_en = cur.v && (cur_rd != 5'd0) && ((cur.op == LOAD_OP) ? exp_rv : 1'b1);
    exp_of1   = (pres.v && writes(pres.op) && pres.op != LOAD_OP) ? pres.rd : 5'd0;
    chk("wr_en", wr_en, exp_wr_en);
    chk("stall_req", o_stall_req, exp_stall);
    chk("of2_reg", of2_reg, exp_wr_en ? cur_rd : 5'd0);
    chk("of1_reg", of1_reg, exp_of1);
    chk("of1_val", of1_val, pres.res);
    chk("mem_load_rd", o_mem_load_rd,
        (pres.v && pres.op == LOAD_OP) ? pres.rd : 5'd0);
    if (exp_wr_en) begin
      chk("wr_reg", wr_reg, cur_rd);
      chk("wr_data", wr_data,
          (cur.op == LOAD_OP) ? ref_align(cur.word, cur.f3, cur.lo) : cur.res);
      chk("of2_val", of2_val, wr_data);
    end
`ifdef TINY_RV_WB_RETIRE_CNT_EN
    chk("instret", o_instret, instret_m);
`endif
  endtask

  task automatic advance();
    @(posedge i_clk);
    if (ld_pending) begin
      if (exp_rv) begin
        ld_pending = 1'b0;
        instret_m  = instret_m + 1;
      end else begin
        ld_wait = ld_wait - 1;
      end
    end
    if (!exp_stall) begin
      cur = pres;
      if (pres.v && pres.op == LOAD_OP) begin
        ld_pending = 1'b1;
        ld_wait    = pres.lat;
      end else if (pres.v) begin
        instret_m = instret_m + 1;
      end
    end
  endtask

  function automatic instr_t rand_instr();
    logic [6:0] op;
    case ($urandom_range(0, 9))
      0:       op = 7'b0110111;
      1:       op = 7'b0010111;
      2:       op = 7'b1101111;
      3:       op = 7'b1100111;
      4:       op = 7'b0010011;
      5:       op = 7'b0110011;
      6, 7:    op = LOAD_OP;
      8:       op = 7'b0100011;
      default: op = 7'($urandom());
    endcase
    return mk($urandom_range(0, 4) != 0, op,
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom()),
              3'($urandom()), $urandom(), 2'($urandom()), $urandom_range(0, 3), $urandom());
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset_n   = 1'b0;
    stray       = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'd0;
    exp_rv      = 1'b0;
    exp_stall   = 1'b0;
    reset_model();
    pres = mk(1'b0, 7'd0, 5'd0, 3'd0, 32'd0, 2'd0, 0, 32'd0);
    nxt  = pres;
    drive_pres();
    #12;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_reg", wr_reg, 5'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_of2_reg", of2_reg, 5'd0);
    chk("rst_of2_val", of2_val, 32'd0);
    chk("rst_stall", o_stall_req, 1'b0);
`ifdef TINY_RV_WB_RETIRE_CNT_EN
    chk("rst_instret", o_instret, 64'd0);
`endif
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // OP writes one cycle after capture.
    nxt = mk(1'b1, 7'b0110011, 5'd5, 3'd0, 32'h1234_5678, 2'd0, 0, 32'd0);
    drive_and_check(); advance();
    nxt = mk(1'b0, 7'd0, 5'd0, 3'd0, 32'd0, 2'd0, 0, 32'd0);
    drive_and_check();
    chk("op_wr_en", wr_en, 1'b1);
    chk("op_wr_reg", wr_reg, 5'd5);
    chk("op_of2_reg", of2_reg, 5'd5);
    chk("op_of2_val", of2_val, 32'h1234_5678);
    advance();

    // LB from the top byte, immediate response.
    nxt = mk(1'b1, LOAD_OP, 5'd9, 3'b000, 32'hDEAD, 2'd3, 0, 32'h80AA_BBCC);
    drive_and_check(); advance();
    nxt = mk(1'b0, 7'd0, 5'd0, 3'd0, 32'd0, 2'd0, 0, 32'd0);
    drive_and_check();
    chk("lb_wr_en", wr_en, 1'b1);
    chk("lb_wr_data", wr_data, 32'hFFFF_FF80);
    chk("lb_stall", o_stall_req, 1'b0);
    advance();

    // LHU upper half, response after 3 cycles.
    nxt = mk(1'b1, LOAD_OP, 5'd12, 3'b101, 32'd0, 2'd2, 3, 32'h8001_0000);
    drive_and_check(); advance();
    nxt = mk(1'b0, 7'd0, 5'd0, 3'd0, 32'd0, 2'd0, 0, 32'd0);
    stall_cnt = 0;
    repeat (3) begin
      drive_and_check();
      if (o_stall_req) stall_cnt++;
      advance();
    end
    chk("lhu_stall_cycles", stall_cnt, 3);
    drive_and_check();
    chk("lhu_stall_end", o_stall_req, 1'b0);
    chk("lhu_wr_data", wr_data, 32'h0000_8001);
    advance();

    // Store never writes.
    nxt = mk(1'b1, 7'b0100011, 5'd7, 3'd2, 32'hCAFE, 2'd0, 0, 32'd0);
    drive_and_check();
    chk("st_of1_reg", of1_reg, 5'd0);
    advance();
    nxt = mk(1'b0, 7'd0, 5'd0, 3'd0, 32'd0, 2'd0, 0, 32'd0);
    drive_and_check();
    chk("st_wr_en", wr_en, 1'b0);
    advance();

    // Reset while waiting on a load, then a stray response.
    nxt = mk(1'b1, LOAD_OP, 5'd3, 3'b010, 32'd0, 2'd0, 10, 32'h5555_AAAA);
    drive_and_check(); advance();
    nxt = mk(1'b0, 7'd0, 5'd0, 3'd0, 32'd0, 2'd0, 0, 32'd0);
    drive_and_check();
    chk("wait_stall", o_stall_req, 1'b1);
    advance();
    #2;
    i_reset_n = 1'b0;
    pres = mk(1'b0, 7'd0, 5'd0, 3'd0, 32'd0, 2'd0, 0, 32'd0);
    drive_pres();
    dmem_rvalid = 1'b0;
    #1;
    chk("rw_wr_en", wr_en, 1'b0);
    chk("rw_wr_reg", wr_reg, 5'd0);
    chk("rw_wr_data", wr_data, 32'd0);
    chk("rw_of2_reg", of2_reg, 5'd0);
    chk("rw_of2_val", of2_val, 32'd0);
    chk("rw_of1_reg", of1_reg, 5'd0);
    chk("rw_load_rd", o_mem_load_rd, 5'd0);
    chk("rw_stall", o_stall_req, 1'b0);
    reset_model();
    exp_rv    = 1'b0;
    exp_stall = 1'b0;
    #1;
    i_reset_n = 1'b1;
    stray = 1'b1;
    drive_and_check();
    chk("stray_wr_en", wr_en, 1'b0);
    chk("stray_stall", o_stall_req, 1'b0);
    advance();
    stray = 1'b0;
    drive_and_check();
    chk("stray_idle", o_stall_req, 1'b0);
    advance();

    // Four ALU ops and one slow load retire five instructions.
    for (int i = 0; i < 4; i++) begin
      nxt = mk(1'b1, (i % 2 == 0) ? 7'b0010011 : 7'b0110011, 5'(i + 1), 3'd0,
               32'(i * 7), 2'd0, 0, 32'd0);
      drive_and_check(); advance();
    end
    nxt = mk(1'b1, LOAD_OP, 5'd20, 3'b010, 32'd0, 2'd0, 2, 32'h0BAD_F00D);
    drive_and_check(); advance();
    nxt = mk(1'b0, 7'd0, 5'd0, 3'd0, 32'd0, 2'd0, 0, 32'd0);
    repeat (4) begin
      drive_and_check(); advance();
    end
`ifdef TINY_RV_WB_RETIRE_CNT_EN
    #1;
    chk("instret_five", o_instret, 64'd5);
`endif

    // Random instruction streams with bubbles and stray responses.
    repeat (400) begin
      nxt   = rand_instr();
      stray = ($urandom_range(0, 3) == 0);
      drive_and_check();
      advance();
    end
    nxt   = mk(1'b0, 7'd0, 5'd0, 3'd0, 32'd0, 2'd0, 0, 32'd0);
    stray = 1'b0;
    repeat (8) begin
      drive_and_check();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
